// File: rtl/display_driver_row_shifter.sv
// Multi-lane LED row shifter: primes the pixel-fetch pipe, then clocks COLUMNS pixels out on a divided oclk.
// Optional DISPLAY_ROW_LOADER_REVERSE_EN shifts the row right-to-left for 180-degree mounted panels.
module display_driver_row_shifter #(
   parameter int COLUMNS     = 32,
   parameter int CHANNELS    = 6,
   parameter int PIPE_LENGTH = 1,
   parameter int CLK_DIV     = 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       start,
   input  logic                       abort,
   output logic [$clog2(COLUMNS)-1:0] column,
   output logic                       pipe_adv,
   input  logic [CHANNELS-1:0]        pixel_in,
   output logic [CHANNELS-1:0]        data_out,
   output logic                       oclk,
   output logic                       busy,
   output logic                       done
);

   localparam int CW      = $clog2(COLUMNS);
   localparam int CNT_MAX = (PIPE_LENGTH > CLK_DIV) ? PIPE_LENGTH : CLK_DIV;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

`ifdef DISPLAY_ROW_LOADER_REVERSE_EN
   localparam logic [CW-1:0] COL_FIRST = CW'(COLUMNS - 1);
   localparam logic [CW-1:0] COL_LAST  = CW'(0);
`else
   localparam logic [CW-1:0] COL_FIRST = CW'(0);
   localparam logic [CW-1:0] COL_LAST  = CW'(COLUMNS - 1);
`endif

   localparam logic [CW-1:0]    COL_END    = CW'(COLUMNS - 1);
   localparam logic [CNT_W-1:0] CNT_ZERO   = CNT_W'(0);
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
   localparam logic [CNT_W-1:0] PRIME_LAST = CNT_W'(PIPE_LENGTH - 1);
   localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(CLK_DIV - 1);
   // Only reachable when CLK_DIV > 1; with CLK_DIV == 1 the advance is issued on LOW entry instead.
   localparam logic [CNT_W-1:0] DIV_PRE    = CNT_W'(CLK_DIV - 2);
   localparam logic             DIV_SINGLE = (CLK_DIV == 1) ? 1'b1 : 1'b0;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      PRIME = 3'd1,
      SETUP = 3'd2,
      LOW   = 3'd3,
      HIGH  = 3'd4,
      DONE  = 3'd5
   } state_t;

   state_t            state_r;
   logic [CNT_W-1:0]  cnt_r;
   logic [CW-1:0]     col_cnt_r;

   function automatic logic [CW-1:0] next_column(input logic [CW-1:0] col);
`ifdef DISPLAY_ROW_LOADER_REVERSE_EN
      return (col == COL_LAST) ? col : col - CW'(1);
`else
      return (col == COL_LAST) ? col : col + CW'(1);
`endif
   endfunction

   // Row sequencer: state, phase/column counters and every registered output.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r   <= IDLE;
         cnt_r     <= CNT_ZERO;
         col_cnt_r <= CW'(0);
         column    <= COL_FIRST;
         pipe_adv  <= 1'b0;
         data_out  <= {CHANNELS{1'b0}};
         oclk      <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         done     <= 1'b0;
         pipe_adv <= 1'b0;
         // The address moves on once the pipe head has captured it.
         if (pipe_adv) begin
            column <= next_column(column);
         end
         case (state_r)
            IDLE: begin
               oclk      <= 1'b0;
               column    <= COL_FIRST;
               cnt_r     <= CNT_ZERO;
               col_cnt_r <= CW'(0);
               if (start) begin
                  busy <= 1'b1;
                  if (PIPE_LENGTH > 0) begin
                     state_r  <= PRIME;
                     pipe_adv <= 1'b1;
                  end else begin
                     state_r <= SETUP;
                  end
               end else begin
                  busy <= 1'b0;
               end
            end
            PRIME: begin
               if (cnt_r == PRIME_LAST) begin
                  state_r <= SETUP;
               end else begin
                  cnt_r    <= cnt_r + CNT_ONE;
                  pipe_adv <= 1'b1;
               end
            end
            SETUP: begin
               state_r   <= LOW;
               data_out  <= pixel_in;
               cnt_r     <= CNT_ZERO;
               col_cnt_r <= CW'(0);
               pipe_adv  <= DIV_SINGLE;
            end
            LOW: begin
               if (cnt_r == DIV_LAST) begin
                  state_r <= HIGH;
                  oclk    <= 1'b1;
                  cnt_r   <= CNT_ZERO;
               end else begin
                  cnt_r    <= cnt_r + CNT_ONE;
                  pipe_adv <= (cnt_r == DIV_PRE) && (col_cnt_r != COL_END);
               end
            end
            HIGH: begin
               if (cnt_r == DIV_LAST) begin
                  oclk  <= 1'b0;
                  cnt_r <= CNT_ZERO;
                  if (col_cnt_r == COL_END) begin
                     state_r <= DONE;
                     done    <= 1'b1;
                  end else begin
                     state_r   <= LOW;
                     data_out  <= pixel_in;
                     col_cnt_r <= col_cnt_r + CW'(1);
                     pipe_adv  <= DIV_SINGLE && ((col_cnt_r + CW'(1)) != COL_END);
                  end
               end else begin
                  cnt_r <= cnt_r + CNT_ONE;
               end
            end
            DONE: begin
               state_r <= IDLE;
               busy    <= 1'b0;
               oclk    <= 1'b0;
               column  <= COL_FIRST;
            end
            default: begin
               state_r <= IDLE;
               busy    <= 1'b0;
               oclk    <= 1'b0;
               column  <= COL_FIRST;
            end
         endcase
         // Abort overrides everything above; the partial row stays in the panel.
         if (abort && (state_r != IDLE)) begin
            state_r  <= IDLE;
            busy     <= 1'b0;
            oclk     <= 1'b0;
            pipe_adv <= 1'b0;
            done     <= 1'b0;
            column   <= COL_FIRST;
            cnt_r    <= CNT_ZERO;
         end
      end
   end

endmodule

// File: tb/tb_display_driver_row_shifter.sv
// Scoreboard bench: two shifters (pipe 2/div 1 and pipe 0/div 3) fed by behavioural pixel pipes.
module tb_display_driver_row_shifter;

   localparam int C  = 4;
   localparam int CH = 6;
`ifdef DISPLAY_ROW_LOADER_REVERSE_EN
   localparam bit REV = 1'b1;
`else
   localparam bit REV = 1'b0;
`endif
   localparam int FIRST = REV ? C - 1 : 0;

   logic          clk = 1'b0;
   logic          rst;
   logic          start_v  [2];
   logic          abort_v  [2];
   logic [1:0]    column_w [2];
   logic          pipe_adv_w [2];
   logic [CH-1:0] pixel_w  [2];
   logic [CH-1:0] data_w   [2];
   logic          oclk_w   [2];
   logic          busy_w   [2];
   logic          done_w   [2];
   logic [CH-1:0] seed = 6'h00;
   bit            mon_on = 1'b0;
   bit            hold_mode = 1'b0;
   int            kill_cnt [2];
   int            n_pass = 0;
   int            n_chk = 0;

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input int got, input int exp);
      n_chk++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
   endtask

   for (genvar g = 0; g < 2; g++) begin : g_inst
      localparam int PL = (g == 0) ? 2 : 0;
      localparam int CD = (g == 0) ? 1 : 3;
      localparam int D  = PL + 2 + 2 * CD * C;
      logic [CH-1:0] stg [4];
      logic [CH-1:0] cur = 6'h00;
      logic [CH-1:0] exp_q [$];
      int rel = -1, rises = 0, advs = 0, rows_done = 0, done_cyc = 0, cyc = 0, kseen = 0;
      int exp_adv, exp_oclk, r, ph, j, ec;
      bit prev_busy = 1'b0, prev_oclk = 1'b0, chain = 1'b0;

      display_driver_row_shifter #(
         .COLUMNS(C), .CHANNELS(CH), .PIPE_LENGTH(PL), .CLK_DIV(CD)
      ) u_dut (
         .clk(clk), .rst(rst), .start(start_v[g]), .abort(abort_v[g]),
         .column(column_w[g]), .pipe_adv(pipe_adv_w[g]), .pixel_in(pixel_w[g]),
         .data_out(data_w[g]), .oclk(oclk_w[g]), .busy(busy_w[g]), .done(done_w[g])
      );

      // Pixel pipe: each captured address returns (address ^ seed) PL advances later.
      always @(posedge clk) begin
         if (pipe_adv_w[g]) begin
            stg[0] <= CH'(column_w[g]) ^ seed;
            for (int i = 1; i < 4; i++) stg[i] <= stg[i-1];
         end
      end
      assign pixel_w[g] = (PL == 0) ? (CH'(column_w[g]) ^ seed) : stg[(PL > 0) ? PL - 1 : 0];

      initial forever begin
         @(negedge clk);
         if (mon_on) begin
            cyc++;
            if (kill_cnt[g] != kseen) begin
               kseen = kill_cnt[g];
               rel = -1;
               exp_q.delete();
            end
            if (busy_w[g] && !prev_busy) begin
               if (chain && hold_mode) check_val("idle_gap", cyc - done_cyc, 2);
               chain = 1'b0;
               rel = 1; rises = 0; advs = 0;
               exp_q.delete();
               for (int k = 0; k < C; k++) exp_q.push_back(CH'(REV ? C - 1 - k : k) ^ seed);
            end else if (rel > 0) begin
               rel++;
            end
            if (rel > 0) begin
               r  = rel - (PL + 2);
               ph = (r >= 0) ? r % (2 * CD) : 0;
               j  = (r >= 0) ? r / (2 * CD) : 0;
               exp_adv  = ((rel <= PL) || (r >= 0 && r < 2*CD*C && ph == CD - 1 && j != C - 1)) ? 1 : 0;
               exp_oclk = (r >= 0 && r < 2*CD*C && ph >= CD) ? 1 : 0;
               check_val("busy", busy_w[g], 1);
               check_val("pipe_adv", pipe_adv_w[g], exp_adv);
               check_val("oclk", oclk_w[g], exp_oclk);
               check_val("done", done_w[g], (rel == D) ? 1 : 0);
               if (pipe_adv_w[g]) begin
                  ec = REV ? ((C - 1 - advs < 0) ? 0 : C - 1 - advs) : ((advs > C - 1) ? C - 1 : advs);
                  check_val("column", column_w[g], ec);
                  advs++;
               end
               if (oclk_w[g] && !prev_oclk) begin
                  rises++;
                  if (exp_q.size() == 0) check_val("extra_rise", exp_q.size(), 1);
                  else begin
                     cur = exp_q.pop_front();
                     check_val("data_rise", data_w[g], cur);
                  end
               end else if (oclk_w[g]) begin
                  check_val("data_hold", data_w[g], cur);
               end
               if (rel == D) begin
                  check_val("adv_count", advs, PL + C - 1);
                  check_val("rise_count", rises, C);
                  check_val("queue_left", exp_q.size(), 0);
                  rows_done++;
                  done_cyc = cyc;
                  chain = hold_mode;
                  rel = -1;
               end
            end else begin
               check_val("idle_busy", busy_w[g], 0);
               check_val("idle_adv", pipe_adv_w[g], 0);
               check_val("idle_oclk", oclk_w[g], 0);
               check_val("idle_done", done_w[g], 0);
               check_val("idle_column", column_w[g], FIRST);
            end
            prev_busy = busy_w[g];
            prev_oclk = oclk_w[g];
         end
      end
   end

   function automatic int rows_of(input int g);
      return (g == 0) ? g_inst[0].rows_done : g_inst[1].rows_done;
   endfunction

   function automatic int rises_of(input int g);
      return (g == 0) ? g_inst[0].rises : g_inst[1].rises;
   endfunction

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic check_rst(input int g);
      check_val("rst_busy", busy_w[g], 0);
      check_val("rst_oclk", oclk_w[g], 0);
      check_val("rst_adv", pipe_adv_w[g], 0);
      check_val("rst_done", done_w[g], 0);
      check_val("rst_data", data_w[g], 0);
      check_val("rst_column", column_w[g], FIRST);
   endtask

   task automatic wait_rows(input int t0, input int t1);
      bit hit = 1'b0;
      for (int i = 0; i < 600 && !hit; i++) begin
         if (rows_of(0) >= t0 && rows_of(1) >= t1) hit = 1'b1;
         else tick();
      end
      check_val("row_timeout", hit, 1);
   endtask

   task automatic wait_idle();
      bit hit = 1'b0;
      for (int i = 0; i < 100 && !hit; i++) begin
         if (!busy_w[0] && !busy_w[1]) hit = 1'b1;
         else tick();
      end
      check_val("idle_timeout", hit, 1);
      tick();
   endtask

   task automatic run_abort(input int g);
      int base;
      bit hit = 1'b0;
      base = rows_of(g);
      start_v[g] = 1'b1; tick(); start_v[g] = 1'b0; tick();
      for (int i = 0; i < 200 && !hit; i++) begin
         if (rises_of(g) >= 3) hit = 1'b1;
         else tick();
      end
      check_val("abort_reach", hit, 1);
      abort_v[g] = 1'b1; tick(); abort_v[g] = 1'b0;
      kill_cnt[g]++;
      repeat (4) tick();
      check_val("abort_nodone", rows_of(g), base);
      start_v[g] = 1'b1; tick(); start_v[g] = 1'b0;
      if (g == 0) wait_rows(base + 1, 0);
      else wait_rows(0, base + 1);
      wait_idle();
   endtask

   initial begin
      int b0, b1;
      rst = 1'b1;
      start_v = '{1'b0, 1'b0};
      abort_v = '{1'b0, 1'b0};
      kill_cnt = '{0, 0};
      repeat (3) tick();
      @(negedge clk);
      check_rst(0);
      check_rst(1);
      tick();
      rst = 1'b0;
      mon_on = 1'b1;
      tick();

      // Single row; a start pulse mid-row must be ignored.
      seed = 6'h15;
      b0 = rows_of(0); b1 = rows_of(1);
      start_v = '{1'b1, 1'b1}; tick(); start_v = '{1'b0, 1'b0};
      repeat (5) tick();
      start_v = '{1'b1, 1'b1}; tick(); start_v = '{1'b0, 1'b0};
      wait_rows(b0 + 1, b1 + 1);
      wait_idle();

      // Start and abort together in IDLE: start wins.
      seed = 6'h33;
      b0 = rows_of(0); b1 = rows_of(1);
      start_v = '{1'b1, 1'b1}; abort_v = '{1'b1, 1'b1}; tick();
      start_v = '{1'b0, 1'b0}; abort_v = '{1'b0, 1'b0};
      wait_rows(b0 + 1, b1 + 1);
      wait_idle();

      // Start held high: back-to-back rows with one IDLE cycle between.
      seed = 6'h2A;
      b0 = rows_of(0); b1 = rows_of(1);
      hold_mode = 1'b1;
      start_v = '{1'b1, 1'b1};
      wait_rows(b0 + 3, b1 + 3);
      start_v = '{1'b0, 1'b0};
      wait_idle();
      hold_mode = 1'b0;

      // Abort at the third oclk rise, then a full row.
      seed = 6'h0C;
      run_abort(0);
      seed = 6'h39;
      run_abort(1);

      // Reset during PRIME.
      seed = 6'h21;
      start_v = '{1'b1, 1'b1}; tick(); start_v = '{1'b0, 1'b0};
      rst = 1'b1; tick(); rst = 1'b0;
      kill_cnt[0]++; kill_cnt[1]++;
      @(negedge clk);
      check_rst(0);
      check_rst(1);
      tick();
      b0 = rows_of(0); b1 = rows_of(1);
      start_v = '{1'b1, 1'b1}; tick(); start_v = '{1'b0, 1'b0};
      wait_rows(b0 + 1, b1 + 1);
      wait_idle();

      // Reset during HIGH.
      seed = 6'h1E;
      start_v = '{1'b1, 1'b1}; tick(); start_v = '{1'b0, 1'b0};
      begin
         bit hit = 1'b0;
         for (int i = 0; i < 50 && !hit; i++) begin
            if (oclk_w[0]) hit = 1'b1;
            else tick();
         end
         check_val("high_reach", hit, 1);
      end
      rst = 1'b1; tick(); rst = 1'b0;
      kill_cnt[0]++; kill_cnt[1]++;
      @(negedge clk);
      check_rst(0);
      check_rst(1);
      tick();
      seed = 6'h07;
      b0 = rows_of(0); b1 = rows_of(1);
      start_v = '{1'b1, 1'b1}; tick(); start_v = '{1'b0, 1'b0};
      wait_rows(b0 + 1, b1 + 1);
      wait_idle();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
